operand_fetch_stage: RTL and testbench
======================================

// Module: operand_fetch_stage
// PURPOSE
//  ID->EX stage of the RISC-V core pipeline. Drives the register file read addresses and registers
//  operands plus control into the ID/EX register. Resolves RAW hazards by forwarding from EX and MEM
//  and by inserting one bubble on load-use.
//  WB->ID needs no bypass: the register file writes on negedge clk and reads combinationally.
// PARAMETERS
//  XLEN     32  operand / result width
//  CTRL_W   16  width of opaque decoded control bundle passed through unchanged
//  CNT_W    16  width of saturating load-use stall counter
// PORTS
//  clk          in   1       clock, posedge
//  rst          in   1       synchronous, active-high reset
//  flush        in   1       kill contents of ID/EX register (branch/jump redirect)
//  in_valid     in   1       decoded instruction present
//  in_ready     out  1       stage accepts instruction this cycle
//  in_rs1       in   5       source reg 1 index
//  in_rs2       in   5       source reg 2 index
//  in_use_rs1   in   1       instruction reads rs1
//  in_use_rs2   in   1       instruction reads rs2
//  in_rd        in   5       destination index
//  in_rd_we     in   1       instruction writes rd
//  in_is_load   in   1       instruction is a load
//  in_ctrl      in   CTRL_W  control bundle
//  rf_rs1_addr  out  5       to regfile rs1_in (= in_rs1, combinational)
//  rf_rs2_addr  out  5       to regfile rs2_in (= in_rs2, combinational)
//  rf_rs1_data  in   XLEN    from regfile rs1_out
//  rf_rs2_data  in   XLEN    from regfile rs2_out
//  ex_result    in   XLEN    ALU result of instruction currently held in ID/EX (out_*)
//  mem_rd       in   5       rd of instruction in MEM
//  mem_rd_we    in   1       MEM instruction writes rd
//  mem_data     in   XLEN    MEM result (load data or ALU result)
//  out_valid    out  1       ID/EX register holds a live instruction
//  out_ready    in   1       EX consumes out_* this cycle
//  out_op1      out  XLEN    resolved rs1 value
//  out_op2      out  XLEN    resolved rs2 value
//  out_rd       out  5       registered in_rd
//  out_rd_we    out  1       registered in_rd_we
//  out_is_load  out  1       registered in_is_load
//  out_ctrl     out  CTRL_W  registered in_ctrl
//  stall_cnt    out  CNT_W   number of load-use bubbles since reset, saturating
// BEHAVIOUR
//  - Reset: out_valid=0, all out_* =0, stall_cnt=0; in_ready=0 while rst high.
//  - hazard = out_valid & out_is_load & out_rd_we & (out_rd!=0)
//      & ((in_use_rs1 & in_rs1==out_rd) | (in_use_rs2 & in_rs2==out_rd)).
//  - in_ready = !rst & !flush & !hazard & (!out_valid | out_ready). Combinational.
//  - Accept = in_valid & in_ready -> next cycle: out_valid=1, operands/control captured.
//    Latency is 1 cycle.
//  - Operand select per source, in priority order:
//    (a) index 0 -> 0;
//    (b) out_valid & out_rd_we & out_rd==idx & !out_is_load -> ex_result;
//    (c) mem_rd_we & mem_rd==idx -> mem_data;
//    (d) rf data.
//    Unused sources (use=0) still select but are don't-care.
//  - If hazard & out_ready: the bubble is inserted and out_valid=0 next cycle.
//    The input is held upstream; next cycle the load sits in MEM and is forwarded via (c).
//    stall_cnt increments once per bubble, saturating at all-ones.
//  - If out_valid & !out_ready & !flush: all out_* hold stable (no update, even if in_valid).
//  - If !in_valid & out_ready: out_valid=0 next cycle. out data may hold old values.
//  - flush: next cycle out_valid=0. It overrides accept, hold and hazard.
//    stall_cnt does not increment in a flush cycle.
//  - rst mid-operation: in-flight instruction discarded, same values as reset.
// TESTING
//  - Reset: rst for 2 cycles, then in_valid=1 -> in_ready=1, out_valid=0, stall_cnt=0;
//    1 cycle later out_valid=1.
//  - EX forward: ADD x5 in ID/EX, ex_result=0x1234; next instr rs1=x5 with rf_rs1_data=0xDEAD
//    -> out_op1=0x1234.
//  - Priority: out_rd=x7 (ex_result=0xAA) and mem_rd=x7 (mem_data=0xBB), rs2=x7 -> out_op2=0xAA.
//    With EX not writing -> 0xBB.
//  - Load-use: LW x3 in ID/EX, next uses rs1=x3, out_ready=1 -> in_ready=0 1 cycle,
//    bubble, stall_cnt=1. Then mem_data=0x55 -> out_op1=0x55.
//  - x0: rs1=x0, mem_rd=x0, mem_rd_we=1, mem_data=0xFF -> out_op1=0, no stall for load to x0.
//  - Backpressure+flush: out_ready=0 for 3 cycles -> out_* stable, in_ready=0.
//    flush pulse -> out_valid=0 next cycle, stall_cnt unchanged.

Source files
------------

// File: rtl/operand_fetch_stage.sv
// Purpose: ID->EX operand fetch. Reads the regfile, forwards results from EX/MEM, and fills the ID/EX register.
// Latency: 1 cycle from accept (in_valid & in_ready) to out_valid.
// Backpressure: holds ID/EX while out_ready=0; a load-use hazard stalls the input and inserts one bubble.
//
// Ports:
//   clk, rst                      clock (posedge) and synchronous active-high reset
//   flush                         kills the ID/EX contents (branch/jump redirect)
//   in_valid/in_ready, in_*       decoded instruction handshake and fields
//   rf_rs1/rs2_addr, rf_*_data    combinational regfile read port
//   ex_result                     result of the instruction now in ID/EX
//   mem_rd, mem_rd_we, mem_data   writeback info from the MEM stage
//   out_valid/out_ready, out_*    ID/EX register contents to EX
//   stall_cnt                     saturating count of load-use bubbles
module operand_fetch_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic              in_use_rs1,
  input  logic              in_use_rs2,
  input  logic [4:0]        in_rd,
  input  logic              in_rd_we,
  input  logic              in_is_load,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic [4:0]        rf_rs1_addr,
  output logic [4:0]        rf_rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  input  logic [XLEN-1:0]   ex_result,
  input  logic [4:0]        mem_rd,
  input  logic              mem_rd_we,
  input  logic [XLEN-1:0]   mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_op1,
  output logic [XLEN-1:0]   out_op2,
  output logic [4:0]        out_rd,
  output logic              out_rd_we,
  output logic              out_is_load,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [4:0]        rd;
    logic              rd_we;
    logic              is_load;
    logic [CTRL_W-1:0] ctrl;
  } idex_t;

  idex_t             idex_q;
  idex_t             idex_d;
  logic              idex_vld;
  logic              hazard;
  logic              accept;
  logic [CNT_W-1:0]  cnt_q;

  // Priority mux for one source. A load in EX has no result yet, so it is
  // excluded from EX forwarding; the hazard logic covers that case instead.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_dat,
    input logic            ex_fwd_ok,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_dat,
    input logic            mem_we,
    input logic [4:0]      m_rd,
    input logic [XLEN-1:0] m_dat
  );
    logic [XLEN-1:0] r;
    r = rf_dat;
    if (idx == 5'd0)                   r = '0;
    else if (ex_fwd_ok && ex_rd == idx) r = ex_dat;
    else if (mem_we && m_rd == idx)    r = m_dat;
    return r;
  endfunction

  logic ex_fwd_ok;
  assign ex_fwd_ok = idex_vld & idex_q.rd_we & ~idex_q.is_load;

  assign rf_rs1_addr = in_rs1;
  assign rf_rs2_addr = in_rs2;

  // Load in EX whose destination is read by the incoming instruction.
  assign hazard = idex_vld & idex_q.is_load & idex_q.rd_we & (idex_q.rd != 5'd0)
                & ((in_use_rs1 & (in_rs1 == idex_q.rd)) | (in_use_rs2 & (in_rs2 == idex_q.rd)));

  assign in_ready = ~rst & ~flush & ~hazard & (~idex_vld | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    idex_d         = idex_q;
    idex_d.op1     = sel_operand(in_rs1, rf_rs1_data, ex_fwd_ok, idex_q.rd, ex_result,
                                 mem_rd_we, mem_rd, mem_data);
    idex_d.op2     = sel_operand(in_rs2, rf_rs2_data, ex_fwd_ok, idex_q.rd, ex_result,
                                 mem_rd_we, mem_rd, mem_data);
    idex_d.rd      = in_rd;
    idex_d.rd_we   = in_rd_we;
    idex_d.is_load = in_is_load;
    idex_d.ctrl    = in_ctrl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_vld <= 1'b0;
      idex_q   <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      idex_vld <= 1'b0;
    end else if (accept) begin
      idex_vld <= 1'b1;
      idex_q   <= idex_d;
    end else if (~idex_vld | out_ready) begin
      // EX drained and nothing new entered: slot empties. With a pending
      // load-use hazard this empty slot is the bubble.
      idex_vld <= 1'b0;
      if (hazard && cnt_q != '1)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = idex_vld;
  assign out_op1     = idex_q.op1;
  assign out_op2     = idex_q.op2;
  assign out_rd      = idex_q.rd;
  assign out_rd_we   = idex_q.rd_we;
  assign out_is_load = idex_q.is_load;
  assign out_ctrl    = idex_q.ctrl;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Purpose: directed bench for operand_fetch_stage with a behavioural reference model.
// Latency: model predicts the ID/EX contents one cycle after each accept.
// Backpressure: stimulus exercises out_ready=0 holds, flush and load-use bubbles.
module tb_operand_fetch_stage;
  localparam int XLEN   = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready;
  logic [4:0]        in_rs1, in_rs2, in_rd;
  logic              in_use_rs1, in_use_rs2, in_rd_we, in_is_load;
  logic [CTRL_W-1:0] in_ctrl;
  logic [4:0]        rf_rs1_addr, rf_rs2_addr;
  logic [XLEN-1:0]   rf_rs1_data, rf_rs2_data, ex_result, mem_data;
  logic [4:0]        mem_rd;
  logic              mem_rd_we;
  logic              out_valid, out_ready;
  logic [XLEN-1:0]   out_op1, out_op2;
  logic [4:0]        out_rd;
  logic              out_rd_we, out_is_load;
  logic [CTRL_W-1:0] out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  operand_fetch_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_use_rs1(in_use_rs1), .in_use_rs2(in_use_rs2),
    .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_ctrl(in_ctrl),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .ex_result(ex_result), .mem_rd(mem_rd), .mem_rd_we(mem_rd_we), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int failures = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit              v;
    logic [4:0]      rd;
    bit              we, ld, u1, u2;
    logic [15:0]     ctrl;
    logic [31:0]     op1, op2;
  } slot_t;

  slot_t m;
  int    m_stalls;

  function automatic bit m_hazard();
    if (!(m.v && m.ld && m.we && m.rd != 0)) return 0;
    return (in_use_rs1 && in_rs1 == m.rd) || (in_use_rs2 && in_rs2 == m.rd);
  endfunction

  function automatic bit m_ready();
    return !rst && !flush && !m_hazard() && (!m.v || out_ready);
  endfunction

  // Value a source register holds as seen from ID: x0 is zero, the newest
  // non-load producer wins, then MEM, then the architectural file.
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 0;
    if (m.v && m.we && !m.ld && m.rd == idx) return ex_result;
    if (mem_rd_we && mem_rd == idx) return mem_data;
    return rf;
  endfunction

  always @(posedge clk) begin
    bit acc, hz;
    acc = in_valid && m_ready();
    hz  = m_hazard();
    if (rst) begin
      m = '{default: 0};
      m_stalls = 0;
    end else if (flush) begin
      m.v = 0;
    end else if (acc) begin
      m.op1 = resolve(in_rs1, rf_rs1_data);
      m.op2 = resolve(in_rs2, rf_rs2_data);
      m.v = 1; m.rd = in_rd; m.we = in_rd_we; m.ld = in_is_load;
      m.u1 = in_use_rs1; m.u2 = in_use_rs2; m.ctrl = in_ctrl;
    end else if (m.v && !out_ready) begin
      // hold
    end else begin
      if (hz && out_ready) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
      m.v = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, m_ready());
      chk("out_valid", out_valid, m.v);
      chk("stall_cnt", stall_cnt, m_stalls);
      chk("rf_rs1_addr", rf_rs1_addr, in_rs1);
      chk("rf_rs2_addr", rf_rs2_addr, in_rs2);
      if (m.v) begin
        chk("out_rd", out_rd, m.rd);
        chk("out_rd_we", out_rd_we, m.we);
        chk("out_is_load", out_is_load, m.ld);
        chk("out_ctrl", out_ctrl, m.ctrl);
        if (m.u1) chk("out_op1", out_op1, m.op1);
        if (m.u2) chk("out_op2", out_op2, m.op2);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input bit u1, input bit u2, input logic [4:0] rd, input bit we,
                       input bit ld, input logic [15:0] ctrl,
                       input logic [31:0] d1, input logic [31:0] d2);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_use_rs1 = u1; in_use_rs2 = u2;
    in_rd = rd; in_rd_we = we; in_is_load = ld; in_ctrl = ctrl;
    rf_rs1_data = d1; rf_rs2_data = d2;
  endtask

  task automatic mem(input bit we, input logic [4:0] rd, input logic [31:0] d);
    mem_rd_we = we; mem_rd = rd; mem_data = d;
  endtask

  initial begin
    m = '{default: 0};
    m_stalls = 0;
    rst = 1; flush = 0; out_ready = 1; ex_result = 0;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem(0, 0, 0);
    tick();
    started = 1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_op1", out_op1, 0);
    chk("rst_out_ctrl", out_ctrl, 0);
    chk("rst_stall", stall_cnt, 0);
    tick();

    // C1: ADD x5 = x1 + x2
    rst = 0;
    instr(1, 1, 2, 1, 1, 5, 1, 0, 16'h0001, 32'h11, 32'h22);
    @(negedge clk);
    chk("c1_in_ready", in_ready, 1);
    chk("c1_out_valid", out_valid, 0);
    tick();

    // C2: reads x5 while ADD x5 is in EX
    ex_result = 32'h1234;
    instr(1, 5, 2, 1, 1, 7, 1, 0, 16'h0002, 32'hDEAD, 32'h22);
    @(negedge clk);
    chk("c2_out_valid", out_valid, 1);
    chk("c2_out_rd", out_rd, 5);
    chk("c2_out_op1", out_op1, 32'h11);
    tick();

    // C3: x7 produced by both EX and MEM; EX wins
    ex_result = 32'hAA;
    mem(1, 7, 32'hBB);
    instr(1, 0, 7, 1, 1, 8, 0, 0, 16'h0003, 32'h99, 32'hCC);
    @(negedge clk);
    chk("ex_fwd_op1", out_op1, 32'h1234);
    tick();

    // C4: EX no longer writes; MEM forwarding applies
    ex_result = 32'h77;
    instr(1, 0, 7, 1, 1, 9, 1, 0, 16'h0004, 32'h99, 32'hCC);
    @(negedge clk);
    chk("prio_ex_op2", out_op2, 32'hAA);
    chk("x0_op1", out_op1, 0);
    tick();

    // C5: LW x3
    mem(0, 0, 0);
    instr(1, 1, 0, 1, 0, 3, 1, 1, 16'h0005, 32'h100, 0);
    @(negedge clk);
    chk("prio_mem_op2", out_op2, 32'hBB);
    tick();

    // C6: use of x3 right behind the load -> stall
    instr(1, 3, 4, 1, 1, 10, 1, 0, 16'h0006, 32'hDEAD, 32'h44);
    @(negedge clk);
    chk("lu_in_ready", in_ready, 0);
    chk("lu_is_load", out_is_load, 1);
    tick();

    // C7: bubble; load now in MEM
    mem(1, 3, 32'h55);
    @(negedge clk);
    chk("lu_bubble", out_valid, 0);
    chk("lu_stall1", stall_cnt, 1);
    chk("lu_retry_ready", in_ready, 1);
    tick();

    // C8: LW x0
    mem(0, 0, 0);
    instr(1, 1, 0, 1, 0, 0, 1, 1, 16'h0007, 32'h100, 0);
    @(negedge clk);
    chk("lu_mem_op1", out_op1, 32'h55);
    tick();

    // C9: reads x0 behind load to x0, MEM claims x0
    mem(1, 0, 32'hFF);
    instr(1, 0, 0, 1, 1, 11, 1, 0, 16'h0008, 32'h12, 32'h34);
    @(negedge clk);
    chk("x0_load_no_stall", in_ready, 1);
    tick();

    // Backpressure for 3 cycles
    mem(0, 0, 0);
    out_ready = 0;
    instr(1, 2, 2, 1, 1, 12, 1, 0, 16'h0009, 32'h5, 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_ctrl", out_ctrl, 16'h0008);
      chk("bp_out_op1", out_op1, 0);
      tick();
    end
    flush = 1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 0);
    tick();
    flush = 0; out_ready = 1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_stall", stall_cnt, 1);
    tick();

    // Flush during a load-use hazard: no bubble counted
    instr(1, 1, 0, 1, 0, 3, 1, 1, 16'h000A, 32'h100, 0);
    tick();
    flush = 1;
    instr(1, 3, 4, 1, 1, 10, 1, 0, 16'h000B, 32'h1, 32'h2);
    @(negedge clk);
    chk("fh_in_ready", in_ready, 0);
    tick();
    flush = 0;
    @(negedge clk);
    chk("fh_out_valid", out_valid, 0);
    chk("fh_stall", stall_cnt, 1);
    tick();

    // Reset mid-operation
    instr(1, 1, 2, 1, 1, 13, 1, 0, 16'h000C, 32'h3, 32'h4);
    tick();
    rst = 1;
    @(negedge clk);
    chk("mid_rst_in_ready", in_ready, 0);
    tick();
    rst = 0;
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_stall", stall_cnt, 0);
    chk("mid_rst_op1", out_op1, 0);
    chk("mid_rst_ctrl", out_ctrl, 0);
    tick();

    // Saturation: more bubbles than the counter can hold
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      instr(1, 1, 0, 1, 0, 3, 1, 1, 16'h0100, 32'h100, 0);
      tick();
      instr(1, 3, 4, 1, 1, 10, 1, 0, 16'h0200, 32'h1, 32'h2);
      tick();
      tick();
    end
    instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    chk("sat_stall", stall_cnt, CNT_MAX);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
